mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 70 +++++++
 rtl/mem_load_align.sv | 39 +++
 rtl/mem_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the MEM pipeline stage.
//   Memory op codes, FSM state encoding, EX/MEM register layout,
//   bubble value and small op-decode helpers.
package mem_stage_pkg;

    // Memory op codes, as carried on the op field from EX
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // PC carried by a bubble (reset vector)
    localparam logic [31:0] PC_BUBBLE = 32'hbfc00000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] aluout;
        logic [31:0] writedata;
        logic [4:0]  writereg;
        logic        regwrite;
        logic        memtoreg;
        logic [5:0]  op;
        logic        en;
        logic [3:0]  sel;
        logic        hilo_write;
        logic [63:0] hilo;
    } exmem_t;

    function automatic exmem_t exmem_bubble();
        exmem_t b;
        b    = '0;
        b.pc = PC_BUBBLE;
        return b;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    // Word ops need a word-aligned address, halfword ops an even one
    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
        case (op)
            OP_LW, OP_SW:         misaligned = (a != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = a[0];
            default:              misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align -- extracts and extends load data from a little-endian
// read word.
//   op_i    load op code
//   addr_i  low two address bits
//   rdata_i word returned by the data bus
//   data_o  register write value (sign/zero extended)
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (op_i)
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'd0, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- EX/MEM pipeline register plus data-bus access FSM.
//   clk, resetn            clock, synchronous active-low reset
//   stall, flush           hold / bubble the EX/MEM register
//   pc..hilo_next          EX results and controls
//   data_*                 SRAM-like data bus (req/addr_ok/data_ok)
//   pcM..hiloM             registered results to WB and forwarding
//   stall_mem              access in flight (to hazard unit)
//   adel, ades             load/store address error
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    input  logic [4:0]  writereg,
    input  logic [1:0]  controls,
    input  logic [5:0]  op,
    input  logic        en,
    input  logic [3:0]  sel,
    input  logic        hilo_write,
    input  logic [63:0] hilo_next,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] pcM,
    output logic [4:0]  writeregM,
    output logic        regwriteM,
    output logic [31:0] resultM,
    output logic        hilo_writeM,
    output logic [63:0] hiloM,
    output logic        stall_mem,
    output logic        adel,
    output logic        ades
);

    exmem_t     ex_d, exm_q, exm_d;
    mem_state_e state_q;
    logic [31:0] rdata_q;
    logic        busy, capture, issue_ok, st_q, ld_q;
    logic [31:0] load_data;

    assign busy = (state_q == S_REQ) || (state_q == S_WAIT);

    // A new op is only taken while no access is in flight
    assign capture = !stall && !busy;

    always_comb begin
        ex_d            = '0;
        ex_d.pc         = pc;
        ex_d.aluout     = aluout;
        ex_d.writedata  = writedata;
        ex_d.writereg   = writereg;
        ex_d.regwrite   = controls[1];
        ex_d.memtoreg   = controls[0];
        ex_d.op         = op;
        ex_d.en         = en;
        ex_d.sel        = sel;
        ex_d.hilo_write = hilo_write;
        ex_d.hilo       = hilo_next;
    end

    always_comb begin
        exm_d = exm_q;
        if (flush)        exm_d = exmem_bubble();
        else if (capture) exm_d = ex_d;
    end

    assign issue_ok = en && (is_load(op) || is_store(op)) && !misaligned(op, aluout[1:0]);

    always_ff @(posedge clk) begin
        if (!resetn) exm_q <= exmem_bubble();
        else         exm_q <= exm_d;
    end

    // Access FSM. A flush while an access is already accepted cannot cancel
    // it on the bus; the bubble's en=0 marks the returning data for discard.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (flush)        state_q <= S_IDLE;
                    else if (!stall)  state_q <= issue_ok ? S_REQ : S_IDLE;
                end
                S_REQ: begin
                    if (data_addr_ok) state_q <= S_WAIT;
                    else if (flush)   state_q <= S_IDLE;
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (exm_q.en && !flush) begin
                            state_q <= S_DONE;
                            rdata_q <= data_rdata;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ld_q = exm_q.en && is_load(exm_q.op);
    assign st_q = exm_q.en && is_store(exm_q.op);

    assign adel = ld_q && misaligned(exm_q.op, exm_q.aluout[1:0]);
    assign ades = st_q && misaligned(exm_q.op, exm_q.aluout[1:0]);

    assign data_req   = (state_q == S_REQ);
    assign data_wr    = data_req && st_q;
    assign data_wstrb = (data_req && st_q) ? exm_q.sel : 4'b0000;
    assign data_addr  = data_req ? {exm_q.aluout[31:2], 2'b00} : 32'd0;
    assign data_wdata = data_req ? exm_q.writedata : 32'd0;
    assign stall_mem  = busy;

    mem_load_align u_align (
        .op_i   (exm_q.op),
        .addr_i (exm_q.aluout[1:0]),
        .rdata_i(rdata_q),
        .data_o (load_data)
    );

    assign pcM         = exm_q.pc;
    assign writeregM   = exm_q.writereg;
    assign regwriteM   = exm_q.regwrite && !adel && !ades;
    assign resultM     = exm_q.memtoreg ? load_data : exm_q.aluout;
    assign hilo_writeM = exm_q.hilo_write;
    assign hiloM       = exm_q.hilo;

endmodule
